// File: rtl/chaos_dac_driver.sv
// chaos_dac_driver
// Buffers x/y/z sample triples from the Lorenz generator in a small FIFO and
// paces them out to a two-channel DAC at one update every DIV clocks.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   in_valid/in_ready   upstream handshake; in_ready = FIFO not full
//   in_x/in_y/in_z      offset-binary samples
//   mode_step           one-cycle pulse, advances channel pairing at next slot
//   mode                0 = A:x B:y, 1 = A:x B:z, 2 = A:y B:z
//   dac_a/dac_b         DAC channel data
//   dac_wrt             DAC write strobe (low first half of period, high second)
//   underrun            sticky: an update slot found the FIFO empty
//   fifo_level          current FIFO occupancy
//
// Optional build macro CHAOS_DAC_GAIN_EN adds gain_sh (deviation from midscale
// is shifted left by gain_sh and saturated) and the sticky sat_hit flag.
module chaos_dac_driver #(
    parameter int DW         = 14,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV        = 8,
    localparam int AW        = $clog2(FIFO_DEPTH),
    localparam int LW        = AW + 1,
    localparam int CW        = $clog2(DIV)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_x,
    input  logic [DW-1:0] in_y,
    input  logic [DW-1:0] in_z,
    input  logic          mode_step,
`ifdef CHAOS_DAC_GAIN_EN
    input  logic [1:0]    gain_sh,
    output logic          sat_hit,
`endif
    output logic [1:0]    mode,
    output logic [DW-1:0] dac_a,
    output logic [DW-1:0] dac_b,
    output logic          dac_wrt,
    output logic          underrun,
    output logic [LW-1:0] fifo_level
);

    localparam logic [DW-1:0] MID = DW'(1) << (DW - 1);

    logic [3*DW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            pend;
    logic            slot, push, pop, adv;
    logic [1:0]      mode_nxt;
    logic [DW-1:0]   hx, hy, hz, sel_a, sel_b, out_a, out_b;

    assign in_ready = (fifo_level != LW'(FIFO_DEPTH));
    assign push     = in_valid && in_ready;
    assign slot     = (cnt == CW'(DIV - 1));
    assign pop      = slot && (fifo_level != '0);
    assign cnt_nxt  = slot ? '0 : cnt + CW'(1);

    // A step pulse landing on the slot cycle itself counts for that slot.
    assign adv      = slot && (pend || mode_step);
    assign mode_nxt = adv ? ((mode == 2'd2) ? 2'd0 : mode + 2'd1) : mode;

    assign {hx, hy, hz} = mem[rd_ptr];

    // Pairing follows the mode that will be current after the slot edge.
    always_comb begin
        sel_a = hx;
        sel_b = hy;
        case (mode_nxt)
            2'd1:    sel_b = hz;
            2'd2:    begin sel_a = hy; sel_b = hz; end
            default: ;
        endcase
    end

`ifdef CHAOS_DAC_GAIN_EN
    localparam int GW = DW + 4;
    logic clip_a, clip_b;

    function automatic logic [DW-1:0] scale(input logic [DW-1:0] s,
                                            input logic [1:0]    sh,
                                            output logic         clip);
        logic signed [GW-1:0] dev, res;
        dev  = $signed(GW'(s)) - $signed(GW'(MID));
        res  = (dev <<< sh) + $signed(GW'(MID));
        clip = 1'b0;
        if (res < 0) begin
            clip  = 1'b1;
            scale = '0;
        end else if (res > $signed(GW'({DW{1'b1}}))) begin
            clip  = 1'b1;
            scale = '1;
        end else begin
            scale = res[DW-1:0];
        end
    endfunction

    always_comb begin
        out_a = scale(sel_a, gain_sh, clip_a);
        out_b = scale(sel_b, gain_sh, clip_b);
    end

    always_ff @(posedge clk) begin
        if (rst)
            sat_hit <= 1'b0;
        else if (pop && (clip_a || clip_b))
            sat_hit <= 1'b1;
    end
`else
    assign out_a = sel_a;
    assign out_b = sel_b;
`endif

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {in_x, in_y, in_z};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LW'(1);
                2'b01:   fifo_level <= fifo_level - LW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            mode     <= 2'd0;
            pend     <= 1'b0;
            dac_a    <= MID;
            dac_b    <= MID;
            dac_wrt  <= 1'b0;
            underrun <= 1'b0;
        end else begin
            cnt     <= cnt_nxt;
            mode    <= mode_nxt;
            // Strobe is low for the first half of each period so it rises
            // DIV/2 clocks after the data loads.
            dac_wrt <= (cnt_nxt >= CW'(DIV / 2));
            if (slot)
                pend <= 1'b0;
            else if (mode_step)
                pend <= 1'b1;
            if (pop) begin
                dac_a <= out_a;
                dac_b <= out_b;
            end else if (slot) begin
                underrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_chaos_dac_driver.sv
module tb_chaos_dac_driver;

    localparam int DW  = 14;
    localparam int DIV = 8;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_x, in_y, in_z;
    logic          mode_step;
    logic [1:0]    mode;
    logic [DW-1:0] dac_a, dac_b;
    logic          dac_wrt;
    logic          underrun;
    logic [2:0]    fifo_level;
`ifdef CHAOS_DAC_GAIN_EN
    logic [1:0]    gain_sh;
    logic          sat_hit;
`endif

    int checks = 0;
    int errors = 0;
    int tb_cnt = 0;
    int idx    = 0;
    logic stream_en = 1'b0;

    chaos_dac_driver #(.DW(DW), .FIFO_DEPTH(4), .DIV(DIV)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_x       (in_x),
        .in_y       (in_y),
        .in_z       (in_z),
        .mode_step  (mode_step),
`ifdef CHAOS_DAC_GAIN_EN
        .gain_sh    (gain_sh),
        .sat_hit    (sat_hit),
`endif
        .mode       (mode),
        .dac_a      (dac_a),
        .dac_b      (dac_b),
        .dac_wrt    (dac_wrt),
        .underrun   (underrun),
        .fifo_level (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_trip(input int x, input int y, input int z);
        in_x = DW'(x);
        in_y = DW'(y);
        in_z = DW'(z);
    endtask

    // One clock; tb_cnt tracks the expected pacer count after the edge.
    // In streaming mode an accepted triple advances the counting pattern.
    task automatic tick();
        logic acc;
        acc = in_valid && in_ready;
        @(posedge clk);
        if (rst) tb_cnt = 0;
        else     tb_cnt = (tb_cnt + 1) % DIV;
        #1;
        if (acc && stream_en) begin
            idx++;
            set_trip('h100 + idx, 'h200 + idx, 'h300 + idx);
        end
    endtask

    // Advance to just after the next slot edge (pacer back at 0).
    task automatic wait_slot();
        for (int i = 0; i < DIV; i++) begin
            tick();
            if (tb_cnt == 0) break;
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; mode_step = 1'b0;
        set_trip(0, 0, 0);
`ifdef CHAOS_DAC_GAIN_EN
        gain_sh = 2'd0;
`endif
        #1;
        // Reset state
        tick(); tick();
        chk("rst_dac_a", 32'(dac_a), 32'h2000);
        chk("rst_dac_b", 32'(dac_b), 32'h2000);
        chk("rst_mode", 32'(mode), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_dac_wrt", 32'(dac_wrt), 32'd0);
        chk("rst_underrun", 32'(underrun), 32'd0);

        // Single triple, first-slot latency
        rst = 1'b0; in_valid = 1'b1;
        set_trip('h1000, 'h2ABC, 'h3FFF);
        tick();
        in_valid = 1'b0;
        chk("one_level", 32'(fifo_level), 32'd1);
        chk("one_dac_hold", 32'(dac_a), 32'h2000);
        wait_slot();
        chk("one_dac_a", 32'(dac_a), 32'h1000);
        chk("one_dac_b", 32'(dac_b), 32'h2ABC);
        chk("one_level_after", 32'(fifo_level), 32'd0);
        chk("one_wrt_low", 32'(dac_wrt), 32'd0);
        chk("one_no_underrun", 32'(underrun), 32'd0);

        // Back-pressure: counting stream held valid
        idx = 0; stream_en = 1'b1; in_valid = 1'b1;
        set_trip('h100, 'h200, 'h300);
        tick(); tick(); tick();
        chk("wrt_low_cnt3", 32'(dac_wrt), 32'd0);
        tick();
        chk("wrt_rise_cnt4", 32'(dac_wrt), 32'd1);
        chk("full_level", 32'(fifo_level), 32'd4);
        chk("full_not_ready", 32'(in_ready), 32'd0);
        chk("full_pushes", 32'(idx), 32'd4);
        tick(); tick(); tick();
        chk("full_hold_level", 32'(fifo_level), 32'd4);
        chk("full_hold_pushes", 32'(idx), 32'd4);
        tick();
        chk("seq0_a", 32'(dac_a), 32'h100);
        chk("seq0_b", 32'(dac_b), 32'h200);
        chk("pop_level", 32'(fifo_level), 32'd3);
        chk("pop_ready", 32'(in_ready), 32'd1);
        chk("pop_wrt_low", 32'(dac_wrt), 32'd0);
        tick();
        chk("refill_level", 32'(fifo_level), 32'd4);
        chk("refill_pushes", 32'(idx), 32'd5);
        for (int k = 1; k <= 4; k++) begin
            wait_slot();
            chk("seq_a", 32'(dac_a), 32'(32'h100 + k));
            chk("seq_b", 32'(dac_b), 32'(32'h200 + k));
        end
        in_valid = 1'b0; stream_en = 1'b0;
        chk("stop_level", 32'(fifo_level), 32'd3);

        // Drain then underrun
        for (int k = 5; k <= 7; k++) begin
            wait_slot();
            chk("drain_a", 32'(dac_a), 32'(32'h100 + k));
            chk("drain_b", 32'(dac_b), 32'(32'h200 + k));
        end
        chk("drained_level", 32'(fifo_level), 32'd0);
        chk("drained_no_underrun", 32'(underrun), 32'd0);
        tick(); tick(); tick(); tick();
        chk("empty_wrt_high", 32'(dac_wrt), 32'd1);
        wait_slot();
        chk("ur_hold_a", 32'(dac_a), 32'h107);
        chk("ur_hold_b", 32'(dac_b), 32'h207);
        chk("ur_set", 32'(underrun), 32'd1);
        chk("ur_wrt_low", 32'(dac_wrt), 32'd0);

        // Mode stepping: two pulses in one period collapse to one advance
        set_trip('h0111, 'h0222, 'h0333);
        in_valid = 1'b1; mode_step = 1'b1;
        tick();
        in_valid = 1'b0; mode_step = 1'b0;
        tick();
        mode_step = 1'b1;
        tick();
        mode_step = 1'b0;
        chk("mode_pending", 32'(mode), 32'd0);
        wait_slot();
        chk("mode1", 32'(mode), 32'd1);
        chk("mode1_a", 32'(dac_a), 32'h0111);
        chk("mode1_b", 32'(dac_b), 32'h0333);
        chk("ur_sticky", 32'(underrun), 32'd1);
        in_valid = 1'b1; mode_step = 1'b1;
        tick();
        in_valid = 1'b0; mode_step = 1'b0;
        wait_slot();
        chk("mode2", 32'(mode), 32'd2);
        chk("mode2_a", 32'(dac_a), 32'h0222);
        chk("mode2_b", 32'(dac_b), 32'h0333);
        in_valid = 1'b1; mode_step = 1'b1;
        tick();
        in_valid = 1'b0; mode_step = 1'b0;
        wait_slot();
        chk("mode0", 32'(mode), 32'd0);
        chk("mode0_a", 32'(dac_a), 32'h0111);
        chk("mode0_b", 32'(dac_b), 32'h0222);

        // Pulse on the slot cycle itself takes effect at that slot
        for (int i = 0; i < DIV - 1; i++) tick();
        chk("pre_slot_mode", 32'(mode), 32'd0);
        mode_step = 1'b1;
        tick();
        mode_step = 1'b0;
        chk("slot_pulse_mode", 32'(mode), 32'd1);
        chk("slot_pulse_hold_a", 32'(dac_a), 32'h0111);
        chk("slot_pulse_hold_b", 32'(dac_b), 32'h0222);

        // Reset mid-transfer discards buffered samples
        in_valid = 1'b1;
        tick(); tick();
        in_valid = 1'b0;
        chk("pre_rst_level", 32'(fifo_level), 32'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_level", 32'(fifo_level), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_mode", 32'(mode), 32'd0);
        chk("mid_rst_underrun", 32'(underrun), 32'd0);
        chk("mid_rst_dac_a", 32'(dac_a), 32'h2000);
        chk("mid_rst_dac_b", 32'(dac_b), 32'h2000);
        chk("mid_rst_wrt", 32'(dac_wrt), 32'd0);
        wait_slot();
        chk("post_rst_hold_a", 32'(dac_a), 32'h2000);
        chk("post_rst_underrun", 32'(underrun), 32'd1);

`ifdef CHAOS_DAC_GAIN_EN
        // Gain with saturation
        rst = 1'b1;
        tick();
        rst = 1'b0;
        gain_sh = 2'd2;
        set_trip('h3000, 'h2000, 'h2000);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_slot();
        chk("gain_sat_a", 32'(dac_a), 32'h3FFF);
        chk("gain_mid_b", 32'(dac_b), 32'h2000);
        chk("gain_sat_hit", 32'(sat_hit), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("gain_rst_sat", 32'(sat_hit), 32'd0);
        set_trip('h2100, 'h2000, 'h2000);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_slot();
        chk("gain_lin_a", 32'(dac_a), 32'h2400);
        chk("gain_no_sat", 32'(sat_hit), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
